// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, MUL FSM encoding and
// the EX/MEM control bubble.
package ex_stage_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_read;
    logic reg_store;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ex_stage_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps.
// o_done is high in the cycle whose closing edge performs the final step.
module ex_stage_mul_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             r_run;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_run    <= 1'b0;
    end else if (i_abort) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_run    <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_count  <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
      if (r_count == CW'(WIDTH - 1)) begin
        r_run <= 1'b0;
      end
    end
  end

  assign o_done    = r_run && (r_count == CW'(WIDTH - 1));
  assign o_product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU with an iterative MUL that stalls
// ID/EX until the product is ready, and the EX/MEM pipeline register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             IRegWrite,
  input  logic             IALUSrc,
  input  logic             IMemWrite,
  input  logic             IMemRead,
  input  logic             IRegStore,
  input  logic [2:0]       IALUOP,
  input  logic [WIDTH-1:0] IPCP2,
  input  logic [WIDTH-1:0] I1stArg,
  input  logic [WIDTH-1:0] I2ndArg,
  input  logic [WIDTH-1:0] IImm,
  input  logic [WIDTH-1:0] IRs1,
  input  logic [WIDTH-1:0] IRs2,
  input  logic [WIDTH-1:0] IRd,
  input  logic             WBRegWrite,
  input  logic [WIDTH-1:0] WBRd,
  input  logic [WIDTH-1:0] WBData,
  input  logic             Flush,
  output logic             ORegWrite,
  output logic             OMemWrite,
  output logic             OMemRead,
  output logic             ORegStore,
  output logic [WIDTH-1:0] OPCP2,
  output logic [WIDTH-1:0] OALUResult,
  output logic [WIDTH-1:0] OStoreData,
  output logic [WIDTH-1:0] ORd,
  output logic             Stall
);

  ctrl_t            r_ctrl;
  logic [WIDTH-1:0] r_pcp2;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_store;
  logic [WIDTH-1:0] r_rd;

  state_e           r_state;
  state_e           w_state_next;

  logic [WIDTH-1:0] w_fwd_a;
  logic [WIDTH-1:0] w_fwd_b;
  logic [WIDTH-1:0] w_alu_b;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_mul_abort;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;
  logic             w_take_product;

  // EX/MEM result takes priority over MEM/WB; register 0 is never forwarded.
  always_comb begin
    w_fwd_a = I1stArg;
    if (r_ctrl.reg_write && (r_rd == IRs1) && (IRs1 != '0)) begin
      w_fwd_a = r_result;
    end else if (WBRegWrite && (WBRd == IRs1) && (IRs1 != '0)) begin
      w_fwd_a = WBData;
    end
  end

  always_comb begin
    w_fwd_b = I2ndArg;
    if (r_ctrl.reg_write && (r_rd == IRs2) && (IRs2 != '0)) begin
      w_fwd_b = r_result;
    end else if (WBRegWrite && (WBRd == IRs2) && (IRs2 != '0)) begin
      w_fwd_b = WBData;
    end
  end

  assign w_alu_b  = IALUSrc ? IImm : w_fwd_b;
  assign w_is_mul = (IALUOP == ALU_MUL);

  always_comb begin
    w_alu_res = '0;
    unique case (IALUOP)
      ALU_ADD: w_alu_res = w_fwd_a + w_alu_b;
      ALU_SUB: w_alu_res = w_fwd_a - w_alu_b;
      ALU_AND: w_alu_res = w_fwd_a & w_alu_b;
      ALU_OR:  w_alu_res = w_fwd_a | w_alu_b;
      ALU_XOR: w_alu_res = w_fwd_a ^ w_alu_b;
      ALU_SLT: w_alu_res = {{(WIDTH - 1){1'b0}}, ($signed(w_fwd_a) < $signed(w_alu_b))};
      ALU_SLL: w_alu_res = w_fwd_a << w_alu_b[3:0];
      ALU_MUL: w_alu_res = '0;
      default: w_alu_res = '0;
    endcase
  end

  ex_stage_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul_seq (
    .i_clk     (CLK),
    .i_rst     (Reset),
    .i_start   (w_mul_start),
    .i_abort   (w_mul_abort),
    .i_a       (w_fwd_a),
    .i_b       (w_alu_b),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_is_mul && !Flush) w_state_next = S_BUSY;
      S_BUSY: begin
        if (Flush) begin
          w_state_next = S_IDLE;
        end else if (w_mul_done) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Stall covers the issuing IDLE cycle plus WIDTH BUSY cycles; reset masks it.
  always_comb begin
    Stall          = 1'b0;
    w_mul_start    = 1'b0;
    w_mul_abort    = 1'b0;
    w_take_product = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        Stall       = !Reset && w_is_mul && !Flush;
        w_mul_start = w_is_mul && !Flush;
      end
      S_BUSY: begin
        Stall       = !Reset;
        w_mul_abort = Flush;
      end
      S_DONE: begin
        w_mul_abort    = Flush;
        w_take_product = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_ctrl   <= CTRL_BUBBLE;
      r_pcp2   <= '0;
      r_result <= '0;
      r_store  <= '0;
      r_rd     <= '0;
    end else if (Flush || Stall) begin
      r_ctrl   <= CTRL_BUBBLE;
      r_pcp2   <= '0;
      r_result <= '0;
      r_store  <= '0;
      r_rd     <= '0;
    end else begin
      r_ctrl   <= '{reg_write: IRegWrite, mem_write: IMemWrite,
                    mem_read: IMemRead, reg_store: IRegStore};
      r_pcp2   <= IPCP2;
      r_result <= w_take_product ? w_mul_product : w_alu_res;
      r_store  <= w_fwd_b;
      r_rd     <= IRd;
    end
  end

  assign ORegWrite  = r_ctrl.reg_write;
  assign OMemWrite  = r_ctrl.mem_write;
  assign OMemRead   = r_ctrl.mem_read;
  assign ORegStore  = r_ctrl.reg_store;
  assign OPCP2      = r_pcp2;
  assign OALUResult = r_result;
  assign OStoreData = r_store;
  assign ORd        = r_rd;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed literal checks plus randomized traffic compared
// every cycle against a behavioural model of the stage.
module tb_ex_stage;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        IRegWrite, IALUSrc, IMemWrite, IMemRead, IRegStore;
  logic [2:0]  IALUOP;
  logic [15:0] IPCP2, I1stArg, I2ndArg, IImm, IRs1, IRs2, IRd;
  logic        WBRegWrite;
  logic [15:0] WBRd, WBData;
  logic        Flush;
  logic        ORegWrite, OMemWrite, OMemRead, ORegStore;
  logic [15:0] OPCP2, OALUResult, OStoreData, ORd;
  logic        Stall;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  ex_stage #(.WIDTH(16)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .IRegWrite  (IRegWrite),
    .IALUSrc    (IALUSrc),
    .IMemWrite  (IMemWrite),
    .IMemRead   (IMemRead),
    .IRegStore  (IRegStore),
    .IALUOP     (IALUOP),
    .IPCP2      (IPCP2),
    .I1stArg    (I1stArg),
    .I2ndArg    (I2ndArg),
    .IImm       (IImm),
    .IRs1       (IRs1),
    .IRs2       (IRs2),
    .IRd        (IRd),
    .WBRegWrite (WBRegWrite),
    .WBRd       (WBRd),
    .WBData     (WBData),
    .Flush      (Flush),
    .ORegWrite  (ORegWrite),
    .OMemWrite  (OMemWrite),
    .OMemRead   (OMemRead),
    .ORegStore  (ORegStore),
    .OPCP2      (OPCP2),
    .OALUResult (OALUResult),
    .OStoreData (OStoreData),
    .ORd        (ORd),
    .Stall      (Stall)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: expected EX/MEM contents and a MUL progress counter
  // (0 idle, 1..16 multiplying, 17 result ready).
  logic        m_rw, m_mw, m_mr, m_rs;
  logic [15:0] m_pc, m_res, m_st, m_rd, m_prod;
  int          m_phase;

  function automatic logic [15:0] ref_fwd(input logic [15:0] rs, input logic [15:0] val);
    if (rs != 0 && m_rw && m_rd == rs) return m_res;
    if (rs != 0 && WBRegWrite && WBRd == rs) return WBData;
    return val;
  endfunction

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      3'd6:    return a << b[3:0];
      default: return a * b;
    endcase
  endfunction

  function automatic logic model_stall();
    return !Reset && ((m_phase == 0 && IALUOP == 3'd7 && !Flush) ||
                      (m_phase >= 1 && m_phase <= 16));
  endfunction

  always @(posedge CLK or posedge Reset) begin : model
    logic [15:0] fa, fb;
    if (Reset) begin
      {m_rw, m_mw, m_mr, m_rs} <= 4'b0;
      m_pc <= 0; m_res <= 0; m_st <= 0; m_rd <= 0; m_prod <= 0;
      m_phase <= 0;
    end else begin
      fa = ref_fwd(IRs1, I1stArg);
      fb = ref_fwd(IRs2, I2ndArg);
      if (Flush || model_stall()) begin
        {m_rw, m_mw, m_mr, m_rs} <= 4'b0;
        m_pc <= 0; m_res <= 0; m_st <= 0; m_rd <= 0;
        if (Flush) m_phase <= 0;
        else if (m_phase == 0) begin
          m_phase <= 1;
          m_prod  <= ref_alu(3'd7, fa, IALUSrc ? IImm : fb);
        end else m_phase <= m_phase + 1;
      end else begin
        {m_rw, m_mw, m_mr, m_rs} <= {IRegWrite, IMemWrite, IMemRead, IRegStore};
        m_pc  <= IPCP2;
        m_res <= (m_phase == 17) ? m_prod : ref_alu(IALUOP, fa, IALUSrc ? IImm : fb);
        m_st  <= fb;
        m_rd  <= IRd;
        m_phase <= 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model Stall", {15'b0, Stall}, {15'b0, model_stall()});
      chk("model ORegWrite", {15'b0, ORegWrite}, {15'b0, m_rw});
      chk("model OMemWrite", {15'b0, OMemWrite}, {15'b0, m_mw});
      chk("model OMemRead", {15'b0, OMemRead}, {15'b0, m_mr});
      chk("model ORegStore", {15'b0, ORegStore}, {15'b0, m_rs});
      chk("model OPCP2", OPCP2, m_pc);
      chk("model OALUResult", OALUResult, m_res);
      chk("model OStoreData", OStoreData, m_st);
      chk("model ORd", ORd, m_rd);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [15:0] rs1, input logic [15:0] a,
                           input logic [15:0] rs2, input logic [15:0] b, input logic [15:0] rd,
                           input logic rw, input logic alusrc, input logic [15:0] imm);
    IALUOP = op; IRs1 = rs1; I1stArg = a; IRs2 = rs2; I2ndArg = b; IRd = rd;
    IRegWrite = rw; IALUSrc = alusrc; IImm = imm;
    IMemWrite = 1'b0; IMemRead = 1'b0; IRegStore = 1'b0; IPCP2 = 16'h0102;
  endtask

  task automatic set_bubble();
    set_instr(3'd0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " ctrl"}, {12'b0, ORegWrite, OMemWrite, OMemRead, ORegStore}, 16'h0);
    chk({name, " OPCP2"}, OPCP2, 16'h0);
    chk({name, " OALUResult"}, OALUResult, 16'h0);
    chk({name, " OStoreData"}, OStoreData, 16'h0);
    chk({name, " ORd"}, ORd, 16'h0);
    chk({name, " Stall"}, {15'b0, Stall}, 16'h0);
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    int n = 0;
    set_instr(3'd7, 0, a, 0, b, 16'd6, 1'b1, 1'b0, 0);
    #1;
    while (Stall === 1'b1 && n < 40) begin
      tick();
      n++;
      chk("mul stall bubble rw", {15'b0, ORegWrite}, 16'h0);
      chk("mul stall bubble res", OALUResult, 16'h0);
      #1;
    end
    chk("mul stall cycles", 16'(n), 16'd17);
    tick();
    set_bubble();
    chk("mul product", OALUResult, exp);
    chk("mul ORegWrite", {15'b0, ORegWrite}, 16'h1);
    chk("mul ORd", ORd, 16'd6);
  endtask

  task automatic rand_instr();
    IALUOP    = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
    IRs1      = 16'($urandom_range(0, 7));
    IRs2      = 16'($urandom_range(0, 7));
    IRd       = 16'($urandom_range(0, 7));
    I1stArg   = 16'($urandom);
    I2ndArg   = 16'($urandom);
    IImm      = 16'($urandom);
    IPCP2     = 16'($urandom);
    IRegWrite = 1'($urandom);
    IALUSrc   = 1'($urandom);
    IMemWrite = 1'($urandom);
    IMemRead  = 1'($urandom);
    IRegStore = 1'($urandom);
  endtask

  initial begin
    bit hold = 1'b0;
    WBRegWrite = 1'b0; WBRd = 0; WBData = 0; Flush = 1'b0;
    set_instr(3'd7, 16'd3, 16'hAAAA, 16'd4, 16'h5555, 16'd9, 1'b1, 1'b1, 16'h1111);
    IMemWrite = 1'b1; IMemRead = 1'b1; IRegStore = 1'b1;
    WBRegWrite = 1'b1; WBRd = 16'd3; WBData = 16'hBEEF;
    #1 Reset = 1'b1;
    chk_en = 1'b1;

    // Reset held with busy inputs
    tick(); tick();
    chk_all_zero("reset");
    Reset = 1'b0;
    WBRegWrite = 1'b0; WBRd = 0; WBData = 0;
    set_instr(3'd0, 0, 16'h1234, 0, 16'h5678, 16'd3, 1'b1, 1'b0, 0);
    tick();
    chk("add result", OALUResult, 16'h68AC);
    chk("add ORegWrite", {15'b0, ORegWrite}, 16'h1);
    chk("add ORd", ORd, 16'd3);

    // EX/MEM forwarding and r0 exclusion
    set_instr(3'd0, 0, 16'h0004, 0, 16'h0001, 16'd3, 1'b1, 1'b0, 0);
    tick();
    set_instr(3'd1, 16'd3, 16'hFFFF, 0, 16'h0002, 16'd5, 1'b1, 1'b0, 0);
    tick();
    chk("exmem fwd sub", OALUResult, 16'h0003);
    set_instr(3'd0, 0, 16'h0004, 0, 16'h0001, 16'd3, 1'b1, 1'b0, 0);
    tick();
    set_instr(3'd1, 16'd0, 16'hFFFF, 0, 16'h0002, 16'd5, 1'b1, 1'b0, 0);
    tick();
    chk("no fwd r0", OALUResult, 16'hFFFD);

    // EX/MEM beats WB on the same index, WB alone still forwards
    set_instr(3'd0, 0, 16'h0100, 0, 16'h0100, 16'd4, 1'b1, 1'b0, 0);
    tick();
    WBRegWrite = 1'b1; WBRd = 16'd4; WBData = 16'h0100;
    set_instr(3'd2, 16'd4, 16'h0000, 0, 16'hFFFF, 16'd7, 1'b1, 1'b0, 0);
    tick();
    chk("exmem over wb", OALUResult, 16'h0200);
    set_instr(3'd2, 16'd4, 16'h0000, 0, 16'hFFFF, 16'd7, 1'b1, 1'b0, 0);
    tick();
    chk("wb fwd", OALUResult, 16'h0100);
    WBRegWrite = 1'b0; WBRd = 0; WBData = 0;

    // ALUSrc, SLT with forwarded rs2, SLL
    set_instr(3'd0, 0, 16'h0003, 0, 16'h7777, 16'd3, 1'b1, 1'b1, 16'hFFFE);
    tick();
    chk("alusrc add", OALUResult, 16'h0001);
    chk("alusrc store", OStoreData, 16'h7777);
    set_instr(3'd5, 0, 16'h8000, 16'd3, 16'h5555, 16'd2, 1'b1, 1'b0, 0);
    tick();
    chk("slt", OALUResult, 16'h0001);
    chk("slt fwd store", OStoreData, 16'h0001);
    set_instr(3'd6, 0, 16'h0001, 0, 16'h0013, 16'd2, 1'b1, 1'b0, 0);
    tick();
    chk("sll", OALUResult, 16'h0008);

    run_mul(16'h0012, 16'h0034, 16'h03A8);
    tick();
    run_mul(16'hFFFF, 16'hFFFF, 16'h0001);
    tick();

    // Flush in BUSY (stall cycle 5)
    set_instr(3'd7, 0, 16'h0012, 0, 16'h0034, 16'd6, 1'b1, 1'b0, 0);
    repeat (4) tick();
    Flush = 1'b1;
    #1;
    chk("flush busy stall", {15'b0, Stall}, 16'h1);
    tick();
    Flush = 1'b0;
    set_bubble();
    #1;
    chk("flush stall drop", {15'b0, Stall}, 16'h0);
    chk("flush bubble", {15'b0, ORegWrite}, 16'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("flush no product", OALUResult, 16'h0);
    end

    // Asynchronous reset mid-MUL (stall cycle 8)
    set_instr(3'd7, 0, 16'h0012, 0, 16'h0034, 16'd6, 1'b1, 1'b0, 0);
    repeat (7) tick();
    #2 Reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    set_instr(3'd0, 0, 16'h0002, 0, 16'h0002, 16'd1, 1'b1, 1'b0, 0);
    #1;
    chk("post reset idle", {15'b0, Stall}, 16'h0);
    tick();
    chk("post reset add", OALUResult, 16'h0004);

    // Randomized traffic; ID/EX holds whenever the model says Stall
    for (int c = 0; c < 3000; c++) begin
      Flush      = ($urandom_range(0, 19) == 0);
      WBRegWrite = 1'($urandom);
      WBRd       = 16'($urandom_range(0, 7));
      WBData     = 16'($urandom);
      if (!hold) rand_instr();
      #1;
      hold = model_stall();
      tick();
    end
    Flush = 1'b0;
    set_bubble();
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit pipeline. It sits directly downstream of the ID/EX register and consumes its outputs.
- Provides operand forwarding, the ALU (including an iterative multi-cycle MUL) and the EX/MEM pipeline register.
- Asserts Stall so the ID/EX register holds while a MUL is in progress; ID/EX write enable = ~Stall.

Parameters:
WIDTH, 16, datapath and register-field width

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high; clears all state
IRegWrite, IALUSrc, IMemWrite, IMemRead, IRegStore  in  1 each  control bits from ID/EX
IALUOP  in  3  ALU operation
IPCP2  in  WIDTH  PC+2 from ID/EX
I1stArg  in  WIDTH  rs1 register value
I2ndArg  in  WIDTH  rs2 register value
IImm  in  WIDTH  sign-extended immediate
IRs1, IRs2, IRd  in  WIDTH  register indices (index 0 never forwarded)
WBRegWrite  in  1  MEM/WB write enable
WBRd  in  WIDTH  MEM/WB destination
WBData  in  WIDTH  MEM/WB writeback value
Flush  in  1  squash instruction in EX (branch taken)
ORegWrite, OMemWrite, OMemRead, ORegStore  out  1 each  EX/MEM control
OPCP2  out  WIDTH  EX/MEM PC+2
OALUResult  out  WIDTH  EX/MEM ALU result
OStoreData  out  WIDTH  EX/MEM forwarded rs2 value (store data)
ORd  out  WIDTH  EX/MEM destination
Stall  out  1  hold ID/EX and upstream stages

Behaviour:
- Reset: all outputs 0 (Stall 0); FSM IDLE; multiplier state cleared. This applies mid-MUL as well.
- Forwarding for A, applied per operand (B uses IRs2 and I2ndArg):
  - EX/MEM priority: ORegWrite && ORd==IRs1 && IRs1!=0 selects OALUResult.
  - Otherwise WBRegWrite && WBRd==IRs1 && IRs1!=0 selects WBData.
  - Otherwise I1stArg.
- B input to the ALU = IALUSrc ? IImm : forwarded B.
- OStoreData always receives forwarded B.
- ALUOP encoding; all arithmetic is modulo 2^WIDTH:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT (signed, result 1 or 0)
  - 110 SLL by B[3:0]
  - 111 MUL (low WIDTH bits of the product)
- Single-cycle ops: EX/MEM captures the result and all pass-through fields on the next rising edge when Stall=0. Latency is 1 cycle.
- MUL FSM has three states: IDLE, BUSY, DONE.
  - IDLE with IALUOP==111 and Flush=0: Stall=1 combinationally. At the edge, forwarded A/B are latched into mul_seq, count=0, next state BUSY.
  - BUSY: Stall=1. One shift-add step per cycle. After WIDTH steps, go to DONE.
  - DONE: Stall=0. At the edge, EX/MEM captures the product with the instruction's controls; FSM returns to IDLE and ID/EX advances.
  - Total Stall cycles = WIDTH+1 (17).
- EX/MEM during Stall=1 edges: loads a bubble (all control bits 0, data fields 0). Forwarding sources are therefore not stale.
- Flush (synchronous, highest priority):
  - At the next edge EX/MEM loads a bubble.
  - If the FSM is BUSY or DONE, it aborts to IDLE without a result, and Stall drops in the cycle after that edge.
  - Flush in IDLE with ALUOP=111 does not start a MUL.
- Bubble input (all control bits 0, ALUOP 000) flows through harmlessly.
- Simultaneous EX/MEM and WB matches on the same index: EX/MEM wins.

Decomposition:
- Shared package holds:
  - ALUOP constants (ALU_ADD … ALU_MUL)
  - FSM state encoding (S_IDLE, S_BUSY, S_DONE)
  - the bubble constant
- One sub-module, mul_seq: iterative shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: done, product.
  - Takes WIDTH cycles and is clearable by abort.
- ex_stage contains the forwarding muxes, ALU, FSM and the EX/MEM register.

Test Plan:
- Reset held 2 cycles with nonzero inputs -> every output 0, Stall 0; after release, ADD 0x1234+0x5678 with IRegWrite=1, IRd=3 -> next edge OALUResult=0x68AC, ORegWrite=1, ORd=3.
- EX/MEM forward: ADD r3=0x0005 followed by SUB IRs1=3, I1stArg=0xFFFF (stale), I2ndArg=0x0002 -> OALUResult=0x0003. With IRs1=0 instead, no forwarding occurs.
- WB vs EX/MEM priority: WBRd=4, WBData=0x0100 and EX/MEM ORd=4, OALUResult=0x0200; AND with A=IRs1=4, B=0xFFFF -> OALUResult=0x0200.
- MUL 0x0012*0x0034:
  - Stall high for exactly 17 cycles, and EX/MEM is a bubble during them.
  - Next edge: OALUResult=0x03A8, ORegWrite=1.
  - Also 0xFFFF*0xFFFF -> 0x0001.
- Flush during BUSY (cycle 5 of MUL) -> EX/MEM bubble, Stall 0 the following cycle, no product ever written. Async Reset at cycle 8 of a MUL -> immediate all-zero, IDLE.
- ALUSrc/SLT/SLL: ALUSrc=1, IImm=0xFFFE, ADD with A=0x0003 -> 0x0001; SLT 0x8000 vs 0x0001 -> 1; SLL 0x0001 by 0x0013 -> 0x0008; OStoreData carries forwarded rs2, not Imm.
